// File: rtl/gray_ptr_sync_rx.sv
// Receive side of a gray-coded pointer link: synchronise, decode to binary, report forward advance.
// Optional illegal-transition checker enabled by defining GRAY_SYNC_ERR_CHECK_EN.
module gray_ptr_sync_rx #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] gray_sync_out,
  output logic [N-1:0] bin_out,
  output logic         adv_valid,
  output logic [N-1:0] adv_count,
  input  logic         err_clr,
  output logic         err_pulse,
  output logic         err_flag
);

  localparam int unsigned CW = $clog2(SYNC_STAGES + 1) + 1;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_init_cnt;
  logic [N-1:0]    r_sync [SYNC_STAGES];
  logic [N-1:0]    w_bin;
  logic [N-1:0]    w_diff;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int unsigned i = 1; i < N; i++) begin
      b[N-1-i] = b[N-i] ^ g[N-1-i];
    end
    return b;
  endfunction

  assign gray_sync_out = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_bin  = g2b(gray_sync_out);
    w_diff = w_bin - bin_out;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_cnt == CW'(SYNC_STAGES)) begin
      w_state_nxt = ST_TRACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      bin_out    <= '0;
      adv_valid  <= 1'b0;
      adv_count  <= '0;
      r_init_cnt <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      bin_out <= w_bin;
      // Strobe is suppressed while the chain fills so a nonzero pointer at release is not an advance.
      if (r_state == ST_TRACK) begin
        adv_count <= w_diff;
        adv_valid <= |w_diff;
      end else begin
        adv_count <= '0;
        adv_valid <= 1'b0;
      end
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

`ifdef GRAY_SYNC_ERR_CHECK_EN
  logic [N-1:0] r_prev_gray;
  logic [N-1:0] w_gray_xor;
  logic         w_multi_bit;
  logic         w_err_set;

  // x & (x-1) is nonzero exactly when more than one bit of x is set.
  always_comb begin
    w_gray_xor  = gray_sync_out ^ r_prev_gray;
    w_multi_bit = |(w_gray_xor & (w_gray_xor - N'(1)));
    w_err_set   = (r_state == ST_TRACK) && w_multi_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      err_pulse   <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      r_prev_gray <= gray_sync_out;
      err_pulse   <= w_err_set;
      if (w_err_set) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_pulse        = 1'b0;
  assign err_flag         = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Directed self-checking bench for gray_ptr_sync_rx (N=8, SYNC_STAGES=2).
module tb_gray_ptr_sync_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gray_in;
  logic [7:0] gray_sync_out;
  logic [7:0] bin_out;
  logic       adv_valid;
  logic [7:0] adv_count;
  logic       err_clr;
  logic       err_pulse;
  logic       err_flag;

  int n_checks = 0;
  int n_errors = 0;

`ifdef GRAY_SYNC_ERR_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  gray_ptr_sync_rx #(.N(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gray_in       (gray_in),
    .gray_sync_out (gray_sync_out),
    .bin_out       (bin_out),
    .adv_valid     (adv_valid),
    .adv_count     (adv_count),
    .err_clr       (err_clr),
    .err_pulse     (err_pulse),
    .err_flag      (err_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] bin_val);
    rst_n   = 1'b0;
    gray_in = b2g(bin_val);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drive one new pointer value and watch four cycles for exactly the expected strobe.
  task automatic step(input logic [7:0] v, input logic [7:0] exp_adv, input int exp_err);
    int         strobes = 0;
    int         errs    = 0;
    int         stray   = 0;
    logic [7:0] cap     = '0;
    gray_in = b2g(v);
    repeat (4) begin
      tick();
      if (adv_valid) begin
        strobes++;
        cap = adv_count;
        check($sformatf("align_%0h", v), bin_out, v);
      end else if (adv_count != 0) begin
        stray++;
      end
      if (err_pulse) errs++;
    end
    check($sformatf("strobes_%0h", v), strobes, (exp_adv != 0) ? 1 : 0);
    check($sformatf("adv_count_%0h", v), cap, exp_adv);
    check($sformatf("idle_count_%0h", v), stray, 0);
    check($sformatf("bin_out_%0h", v), bin_out, v);
    check($sformatf("err_pulses_%0h", v), errs, exp_err);
  endtask

  task automatic count_strobes(input int cycles, output int strobes);
    strobes = 0;
    repeat (cycles) begin
      tick();
      if (adv_valid) strobes++;
    end
  endtask

  initial begin
    int         s;
    logic [7:0] pos;
    logic [7:0] sum;

    err_clr = 1'b0;
    rst_n   = 1'b0;
    gray_in = '0;
    #3;
    check("rst_bin_out", bin_out, 0);
    check("rst_gray_sync", gray_sync_out, 0);
    check("rst_adv_valid", adv_valid, 0);
    check("rst_adv_count", adv_count, 0);
    check("rst_err_flag", err_flag, 0);

    // 1: incrementing walk 0..20
    do_reset(8'h00);
    count_strobes(5, s);
    check("t1_init_strobes", s, 0);
    for (int v = 1; v <= 20; v++) step(8'(v), 8'd1, 0);

    // 2: nonzero pointer through reset release, then held stable
    do_reset(8'hA5);
    tick();
    tick();
    check("t2_gray_sync", gray_sync_out, b2g(8'hA5));
    check("t2_bin_before", bin_out, 0);
    tick();
    check("t2_bin_after3", bin_out, 8'hA5);
    count_strobes(20, s);
    check("t2_strobes", s, 0);
    check("t2_bin_hold", bin_out, 8'hA5);

    // 3: wrap FF -> 00
    do_reset(8'hFD);
    count_strobes(5, s);
    check("t3_init_strobes", s, 0);
    step(8'hFE, 8'd1, 0);
    step(8'hFF, 8'd1, 0);
    step(8'h00, 8'd1, 0);

    // 4: multi-step jumps; 0x18->0x1A is one bit, 0x1A->0x30 is three bits
    do_reset(8'h10);
    count_strobes(5, s);
    step(8'h13, 8'd3, 0);
    check("t4_flag_after_legal", err_flag, 0);
    step(8'h20, 8'h0D, ERR_ON);
    check("t4_flag_sticky", err_flag, ERR_ON);
    tick();
    check("t4_flag_still", err_flag, ERR_ON);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_flag_cleared", err_flag, 0);

    // 5: asynchronous reset mid-stream
    do_reset(8'h3F);
    count_strobes(5, s);
    step(8'h40, 8'd1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_bin_async", bin_out, 0);
    check("t5_gray_async", gray_sync_out, 0);
    check("t5_valid_async", adv_valid, 0);
    check("t5_count_async", adv_count, 0);
    gray_in = b2g(8'h41);
    tick();
    rst_n = 1'b1;
    count_strobes(3, s);
    check("t5_bin_release", bin_out, 8'h41);
    count_strobes(10, s);
    check("t5_strobes", s, 0);

    // 6: random single-step walk; accumulated advance must equal final pointer
    do_reset(8'h00);
    count_strobes(5, s);
    pos = '0;
    sum = '0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) != 0) pos = pos + 8'd1;
      else                           pos = pos - 8'd1;
      gray_in = b2g(pos);
      tick();
      sum = sum + adv_count;
    end
    repeat (4) begin
      tick();
      sum = sum + adv_count;
    end
    check("t6_bin_model", bin_out, pos);
    check("t6_sum", sum, bin_out);
    check("t6_err_flag", err_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
